fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences the program counter through instruction fetch.
- Holds the PC register, issues request/acknowledge transfers to instruction memory, and presents fetched instructions to decode with a valid/ready handshake.
- Applies branch/jump redirects coming from the ALU.
- Sits between the PC datapath (PCSel/ALU_out source) and the decode stage. Replaces free-running PC+4 sequencing with a memory-latency-tolerant controller.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 16, cycles WAIT may spend without imem_ack before a fetch timeout (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- redirect_valid  input  1  one-cycle redirect strobe (PCSel from execute).
- redirect_target  input  32  new PC (ALU_out).
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ack  input  1  memory acknowledge; imem_rdata is valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- inst_valid  output  1  inst/inst_pc hold a valid instruction.
- inst_ready  input  1  decode accepts the instruction.
- inst  output  32  instruction to decode.
- inst_pc  output  32  address of inst.
- pc  output  32  current fetch PC.
- fetch_err  output  1  sticky fetch-timeout flag.
- misalign_err  output  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high, on rst.
- Reset values: pc=RESET_VEC, state=IDLE, wait_cnt=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, misalign_err=0.
- Reset mid-operation: abandons any request immediately. A late imem_ack after reset release is ignored unless the FSM is in WAIT.
- States: IDLE, WAIT, VALID, ERR.
- IDLE: imem_req=0. Moves to WAIT on the first clock after rst deasserts.
- WAIT:
  - imem_req=1, imem_addr=pc.
  - A same-cycle ack is allowed; memory may see req withdrawn or the address changed before ack.
  - On imem_ack: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4 (32-bit, carry discarded; 32'hFFFF_FFFC wraps to 0), wait_cnt<=0, go to VALID.
  - No ack: wait_cnt increments. When wait_cnt==MAX_WAIT-1 with no ack, go to ERR and set fetch_err=1.
  - Minimum fetch latency is one cycle from WAIT entry to inst_valid=1.
- VALID:
  - inst_valid=1, imem_req=0.
  - inst and inst_pc stay stable while inst_ready=0.
  - When inst_ready=1: inst_valid drops next cycle and the FSM returns to WAIT.
  - Sustained throughput is one instruction per 2 cycles.
- ERR:
  - imem_req=0, inst_valid=0.
  - Stays in ERR until rst or redirect_valid.
- Redirect (any state, priority over ack and timeout):
  - pc<=redirect_target, wait_cnt<=0, fetch_err<=0, next state WAIT.
  - In WAIT with a same-cycle ack: rdata is discarded.
  - In VALID with inst_ready=0: the held instruction is squashed (inst_valid=0 next cycle).
  - In VALID with inst_ready=1: the instruction counts as consumed, then the redirect applies.
- Overall priority: rst > redirect_valid > imem_ack > timeout.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_target[1:0]!=0 loads pc<=redirect_target, sets misalign_err=1, and goes to ERR without issuing a request.
  - misalign_err is cleared by rst or by an aligned redirect.
- Undefined:
  - redirect_target[1:0] is forced to 2'b00 when loaded into pc.
  - misalign_err is tied 0.

Test Plan:
- Reset, then ack one cycle after each imem_req, inst_ready=1 -> imem_addr sequence 0,4,8; inst_pc matches; inst_valid pulses every 2nd cycle.
- inst_ready=0 for 5 cycles in VALID -> inst/inst_pc stable, imem_req=0, pc already +4.
- redirect_valid=1, target=32'h100, in the same cycle as imem_ack -> rdata dropped, next imem_addr=32'h100, no inst_valid for the old word.
- No ack for MAX_WAIT=16 cycles -> fetch_err=1 and imem_req=0 after 16 WAIT cycles; redirect to 32'h40 clears fetch_err and requests 32'h40.
- pc=32'hFFFF_FFFC, ack -> pc wraps to 0; assert rst mid-WAIT -> all outputs return to reset values asynchronously.
- Redirect to 32'h102: with FETCH_MISALIGN_TRAP_EN -> misalign_err=1, state ERR, no imem_req; without the macro -> imem_addr=32'h100.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC register, imem req/ack sequencing, decode valid/ready handoff, redirects.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap misaligned redirect targets).
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic        misalign_err
);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [7:0]  wait_cnt_q;
  logic        imem_req_q;
  logic        inst_valid_q;
  logic        fetch_err_q;
  logic        misalign_err_q;

  logic [31:0] redir_pc;
  logic        redir_trap;

  // Without the trap, misaligned targets are silently rounded down to a word boundary.
  always_comb begin
    redir_trap = TRAP_EN & (redirect_target[1:0] != 2'b00);
    if (TRAP_EN) begin
      redir_pc = redirect_target;
    end else begin
      redir_pc = {redirect_target[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_VEC;
      inst_q         <= 32'h0000_0000;
      inst_pc_q      <= 32'h0000_0000;
      wait_cnt_q     <= 8'd0;
      imem_req_q     <= 1'b0;
      inst_valid_q   <= 1'b0;
      fetch_err_q    <= 1'b0;
      misalign_err_q <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over ack and timeout; any held or arriving instruction is dropped.
      pc_q         <= redir_pc;
      wait_cnt_q   <= 8'd0;
      fetch_err_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      if (redir_trap) begin
        state_q        <= ERR;
        imem_req_q     <= 1'b0;
        misalign_err_q <= 1'b1;
      end else begin
        state_q        <= WAIT;
        imem_req_q     <= 1'b1;
        misalign_err_q <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= WAIT;
          imem_req_q <= 1'b1;
          wait_cnt_q <= 8'd0;
        end
        WAIT: begin
          if (imem_ack) begin
            inst_q       <= imem_rdata;
            inst_pc_q    <= pc_q;
            pc_q         <= pc_q + 32'd4;
            wait_cnt_q   <= 8'd0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b1;
            state_q      <= VALID;
          end else if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_q  <= 8'd0;
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= ERR;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        VALID: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
            state_q      <= WAIT;
          end else begin
            inst_valid_q <= 1'b1;
          end
        end
        ERR: begin
          imem_req_q   <= 1'b0;
          inst_valid_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          imem_req_q   <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign inst_valid   = inst_valid_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign fetch_err    = fetch_err_q;
  assign misalign_err = misalign_err_q;

endmodule
